// File: rtl/aoc_frame_rx.sv
// aoc_frame_rx: UART (8E1) receiver, AoC frame header parser and packed-BCD
// unpacker. It emits one BCD digit per cycle, with line and frame boundary flags.
module aoc_frame_rx #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int BAUD_RATE      = 921_600,
  parameter int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        uart_txd_in,
  output logic        hdr_valid,
  output logic [7:0]  line_len,
  output logic [11:0] line_count,
  output logic [3:0]  num_digits,
  output logic        digit_valid,
  output logic [3:0]  digit,
  output logic        line_end,
  output logic        frame_end,
  output logic        parity_err,
  output logic        stop_err,
  output logic        hdr_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CYCLES_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_WAIT_SYNC, P_HDR_LEN, P_HDR_YH, P_HDR_YL, P_DATA} p_state_t;

  rx_state_t        rx_state, rx_next;
  p_state_t         p_state, p_next;
  logic             rx_p0, rx_p1, rx_p2;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_p0;
  logic             par_bit;
  logic             byte_stb, par_fail, stop_fail;
  logic             hdr_ok, hdr_bad, last_byte, last_line;
  logic [7:0]       len_sh, yh_sh;
  logic [11:0]      yyy;
  logic [7:0]       byte_cnt;
  logic [11:0]      line_cnt;
  logic             vld_p0, line_p0, frame_p0;
  logic [3:0]       nib_p0;

  assign yyy = {yh_sh, shift_p0[7:4]};

  // Stage p0/p1: metastability synchroniser; p2 is the history flop for the edge detect
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_txd_in;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Arming: a framing error disarms until the line has been seen idle-high again
  always_ff @(posedge sysclk) begin
    if (rst)            armed <= 1'b0;
    else if (stop_fail) armed <= 1'b0;
    else if (rx_p1)     armed <= 1'b1;
  end

  // RX state register
  always_ff @(posedge sysclk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state and character check at the stop-bit sample
  always_comb begin
    rx_next   = rx_state;
    byte_stb  = 1'b0;
    par_fail  = 1'b0;
    stop_fail = 1'b0;
    case (rx_state)
      RX_IDLE:   if (armed && rx_p2 && !rx_p1) rx_next = RX_START;
      RX_START:  if (cnt == HALF_CNT) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (cnt == LAST_CNT && bit_idx == 3'd7) rx_next = RX_PARITY;
      RX_PARITY: if (cnt == LAST_CNT) rx_next = RX_STOP;
      RX_STOP: begin
        if (cnt == LAST_CNT) begin
          rx_next   = RX_IDLE;
          par_fail  = ^{shift_p0, par_bit};
          stop_fail = !rx_p1;
          byte_stb  = !par_fail && rx_p1;
        end
      end
      default:   rx_next = RX_IDLE;
    endcase
  end

  // Bit timing counter: restarts at mid start bit, then fires every bit period
  always_ff @(posedge sysclk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      if (rx_state == RX_IDLE)
        cnt <= '0;
      else if ((rx_state == RX_START) ? (cnt == HALF_CNT) : (cnt == LAST_CNT))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (rx_state == RX_START)
        bit_idx <= '0;
      else if (rx_state == RX_DATA && cnt == LAST_CNT)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Data and parity capture, LSB first
  always_ff @(posedge sysclk) begin
    if (rx_state == RX_DATA && cnt == LAST_CNT)   shift_p0 <= {rx_p1, shift_p0[7:1]};
    if (rx_state == RX_PARITY && cnt == LAST_CNT) par_bit  <= rx_p1;
  end

  // Character error pulses
  always_ff @(posedge sysclk) begin
    if (rst) begin
      parity_err <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      parity_err <= par_fail;
      stop_err   <= stop_fail;
    end
  end

  // Parser state register
  always_ff @(posedge sysclk) begin
    if (rst) p_state <= P_WAIT_SYNC;
    else     p_state <= p_next;
  end

  // Parser next state, header validation and position decode
  always_comb begin
    p_next    = p_state;
    hdr_ok    = 1'b0;
    hdr_bad   = 1'b0;
    last_byte = (byte_cnt == line_len - 8'd1);
    last_line = (line_cnt == line_count - 12'd1);
    if (byte_stb) begin
      case (p_state)
        P_WAIT_SYNC: if (shift_p0 == 8'hAA) p_next = P_HDR_LEN;
        P_HDR_LEN:   p_next = P_HDR_YH;
        P_HDR_YH:    p_next = P_HDR_YL;
        P_HDR_YL: begin
          if (len_sh == 8'd0 || yyy == 12'd0) begin
            hdr_bad = 1'b1;
            p_next  = P_WAIT_SYNC;
          end else begin
            hdr_ok = 1'b1;
            p_next = P_DATA;
          end
        end
        P_DATA:      if (last_byte && last_line) p_next = P_WAIT_SYNC;
        default:     p_next = P_WAIT_SYNC;
      endcase
    end
  end

  // Header shadow registers; only published once the whole header is accepted
  always_ff @(posedge sysclk) begin
    if (byte_stb && p_state == P_HDR_LEN) len_sh <= shift_p0;
    if (byte_stb && p_state == P_HDR_YH)  yh_sh  <= shift_p0;
  end

  // Stage p0: low nibble and its boundary flags held for the second unpack cycle
  always_ff @(posedge sysclk) begin
    if (byte_stb && p_state == P_DATA) begin
      nib_p0   <= shift_p0[3:0];
      line_p0  <= last_byte;
      frame_p0 <= last_byte && last_line;
    end
  end

  // Header outputs, frame position counters, digit stream and busy
  always_ff @(posedge sysclk) begin
    if (rst) begin
      hdr_valid   <= 1'b0;
      hdr_err     <= 1'b0;
      busy        <= 1'b0;
      line_len    <= '0;
      line_count  <= '0;
      num_digits  <= '0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      digit_valid <= 1'b0;
      digit       <= '0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      hdr_valid   <= hdr_ok;
      hdr_err     <= hdr_bad;
      digit_valid <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      if (byte_stb && p_state == P_WAIT_SYNC && shift_p0 == 8'hAA)
        busy <= 1'b1;
      else if (hdr_bad || (vld_p0 && frame_p0))
        busy <= 1'b0;
      if (hdr_ok) begin
        line_len   <= len_sh;
        line_count <= yyy;
        num_digits <= shift_p0[3:0];
        byte_cnt   <= '0;
        line_cnt   <= '0;
      end
      if (byte_stb && p_state == P_DATA) begin
        digit_valid <= 1'b1;
        digit       <= shift_p0[7:4];
        vld_p0      <= 1'b1;
        if (last_byte) begin
          byte_cnt <= '0;
          line_cnt <= line_cnt + 12'd1;
        end else begin
          byte_cnt <= byte_cnt + 8'd1;
        end
      end else if (vld_p0) begin
        digit_valid <= 1'b1;
        digit       <= nib_p0;
        line_end    <= line_p0;
        frame_end   <= frame_p0;
        vld_p0      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aoc_frame_rx.sv
// Directed bench for aoc_frame_rx: drives 8E1 UART characters and checks the
// header fields, the digit stream and the error pulses.
module tb_aoc_frame_rx;

  localparam int CPB = 12_000_000 / 921_600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart = 1'b1;
  logic        hdr_valid, digit_valid, line_end, frame_end;
  logic        parity_err, stop_err, hdr_err, busy;
  logic [7:0]  line_len;
  logic [11:0] line_count;
  logic [3:0]  num_digits, digit;

  aoc_frame_rx dut (
    .sysclk(clk), .rst(rst), .uart_txd_in(uart),
    .hdr_valid(hdr_valid), .line_len(line_len), .line_count(line_count),
    .num_digits(num_digits), .digit_valid(digit_valid), .digit(digit),
    .line_end(line_end), .frame_end(frame_end), .parity_err(parity_err),
    .stop_err(stop_err), .hdr_err(hdr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int     n_assert = 0;
  int     n_fail = 0;
  int     n_dig = 0, n_le = 0, n_fe = 0, n_hv = 0, n_pe = 0, n_se = 0, n_he = 0;
  int     s_dig, s_le, s_fe, s_hv, s_pe, s_se, s_he;
  int     hv_len = 0;
  longint cyc = 0;
  int     dig_log [0:2047];
  bit     le_log  [0:2047];
  bit     fe_log  [0:2047];
  longint stamp   [0:2047];
  logic [7:0] frame_bytes [0:249];

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (digit_valid) begin
      dig_log[n_dig & 2047] <= int'(digit);
      le_log[n_dig & 2047]  <= line_end;
      fe_log[n_dig & 2047]  <= frame_end;
      stamp[n_dig & 2047]   <= cyc;
      n_dig <= n_dig + 1;
    end
    if (line_end)   n_le <= n_le + 1;
    if (frame_end)  n_fe <= n_fe + 1;
    if (hdr_valid) begin
      n_hv   <= n_hv + 1;
      hv_len <= int'(line_len);
    end
    if (parity_err) n_pe <= n_pe + 1;
    if (stop_err)   n_se <= n_se + 1;
    if (hdr_err)    n_he <= n_he + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_dig = n_dig; s_le = n_le; s_fe = n_fe; s_hv = n_hv;
    s_pe = n_pe; s_se = n_se; s_he = n_he;
  endtask

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] b, input bit bad_par = 1'b0,
                           input bit bad_stop = 1'b0, input int low_bits = 0);
    logic p;
    p = (^b) ^ bad_par;
    uart = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      uart = b[i];
      bit_time();
    end
    uart = p;
    bit_time();
    uart = !bad_stop;
    bit_time();
    if (bad_stop) repeat (low_bits) bit_time();
    uart = 1'b1;
    bit_time();
  endtask

  initial begin
    int bad_d, bad_le, bad_fe, base;
    logic [7:0] b;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", {hdr_valid, digit_valid, line_end, frame_end}, 0);
    chk("rst_errors", {parity_err, stop_err, hdr_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {line_len, line_count, num_digits, digit}, 0);
    repeat (3) bit_time();

    // Junk before sync
    snap();
    send_char(8'h00); send_char(8'h55); send_char(8'hAB);
    chk("junk_events", (n_dig - s_dig) + (n_hv - s_hv) + (n_pe - s_pe) + (n_se - s_se) + (n_he - s_he), 0);
    chk("junk_busy", busy, 0);

    // Header AA 32 00 5C
    snap();
    send_char(8'hAA);
    chk("sync_busy", busy, 1);
    send_char(8'h32); send_char(8'h00); send_char(8'h5C);
    chk("hdr_count", n_hv - s_hv, 1);
    chk("hdr_len_at_pulse", hv_len, 50);
    chk("hdr_line_len", line_len, 50);
    chk("hdr_line_count", line_count, 5);
    chk("hdr_num_digits", num_digits, 12);
    chk("hdr_busy", busy, 1);

    // 5 lines x 50 bytes
    for (int k = 0; k < 250; k++) frame_bytes[k] = 8'((k * 37 + 22) & 255);
    snap();
    for (int k = 0; k < 250; k++) send_char(frame_bytes[k]);
    chk("frame_digits", n_dig - s_dig, 500);
    chk("frame_line_ends", n_le - s_le, 5);
    chk("frame_frame_ends", n_fe - s_fe, 1);
    chk("first_digit_hi", dig_log[s_dig & 2047], 1);
    chk("first_digit_lo", dig_log[(s_dig + 1) & 2047], 6);
    chk("first_digit_gap", stamp[(s_dig + 1) & 2047] - stamp[s_dig & 2047], 1);
    bad_d = 0; bad_le = 0; bad_fe = 0;
    for (int i = 0; i < 500; i++) begin
      b = frame_bytes[i / 2];
      if (dig_log[(s_dig + i) & 2047] != ((i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]))) bad_d++;
      if (le_log[(s_dig + i) & 2047] != (i % 100 == 99)) bad_le++;
      if (fe_log[(s_dig + i) & 2047] != (i == 499)) bad_fe++;
    end
    chk("frame_digit_values", bad_d, 0);
    chk("frame_line_end_pos", bad_le, 0);
    chk("frame_frame_end_pos", bad_fe, 0);
    chk("frame_busy_after", busy, 0);

    // Parity error on header byte, then resend
    snap();
    send_char(8'hAA);
    send_char(8'h32, 1'b1);
    chk("par_err_count", n_pe - s_pe, 1);
    chk("par_no_hdr", n_hv - s_hv, 0);
    send_char(8'h32); send_char(8'h00); send_char(8'h5C);
    chk("par_resend_hdr", n_hv - s_hv, 1);
    chk("par_resend_len", hv_len, 50);
    chk("par_busy", busy, 1);

    // Stop-bit error with line held low, then a clean character
    snap();
    send_char(8'h16, 1'b0, 1'b1, 50);
    chk("stop_err_count", n_se - s_se, 1);
    chk("stop_no_parity", n_pe - s_pe, 0);
    chk("stop_no_digits", n_dig - s_dig, 0);
    send_char(8'h16);
    chk("stop_next_digits", n_dig - s_dig, 2);
    chk("stop_next_hi", dig_log[s_dig & 2047], 1);
    chk("stop_next_lo", dig_log[(s_dig + 1) & 2047], 6);
    chk("stop_busy", busy, 1);

    // Finish line 1 and enter line 2, then reset mid-byte
    snap();
    for (int k = 0; k < 50; k++) send_char(8'h27);
    chk("line2_line_end", n_le - s_le, 1);
    chk("line2_digits", n_dig - s_dig, 100);
    fork
      send_char(8'hFF);
      begin
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        snap();
      end
    join
    chk("midrst_busy", busy, 0);
    chk("midrst_line_len", line_len, 0);
    repeat (20) bit_time();
    chk("midrst_no_digits", n_dig - s_dig, 0);

    // New header AA 01 00 11 and byte 0x98
    snap();
    send_char(8'hAA); send_char(8'h01); send_char(8'h00); send_char(8'h11);
    chk("small_hdr", n_hv - s_hv, 1);
    chk("small_fields", {line_len, line_count, num_digits}, {8'd1, 12'd1, 4'd1});
    send_char(8'h98);
    base = s_dig;
    chk("small_digits", n_dig - s_dig, 2);
    chk("small_d0", dig_log[base & 2047], 9);
    chk("small_d1", dig_log[(base + 1) & 2047], 8);
    chk("small_flags_d0", {le_log[base & 2047], fe_log[base & 2047]}, 0);
    chk("small_flags_d1", {le_log[(base + 1) & 2047], fe_log[(base + 1) & 2047]}, 3);
    chk("small_busy", busy, 0);

    // Rejected header AA 00 00 11
    snap();
    send_char(8'hAA); send_char(8'h00); send_char(8'h00); send_char(8'h11);
    chk("bad_hdr_err", n_he - s_he, 1);
    chk("bad_hdr_no_valid", n_hv - s_hv, 0);
    chk("bad_hdr_fields", {line_len, line_count, num_digits}, {8'd1, 12'd1, 4'd1});
    chk("bad_hdr_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
